mealy_moore: RTL and testbench

Serial pattern detector containing two functionally equivalent finite-state machines side by side: a Mealy machine and a Moore machine. Both watch the same 1-bit serial input `din`, sampled once per clock. Both flag every occurrence of the bit pattern 1-0-1-0 in arrival order, with overlapping matches allowed. The block serves as a comparison and teaching unit: both flags are exported so their relative timing can be observed on the same stimulus.

---
 rtl/mealy_moore.sv | 110 +++++++++++
 tb/tb_mealy_moore.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mealy_moore.sv
// mealy_moore: serial 1010 pattern detector built twice, once as a Mealy
// machine and once as a Moore machine, so the timing of the two flags can be
// compared on the same input stream. Overlapping matches are detected.
//
// Ports:
//   clk          system clock, state updates on the rising edge
//   rst          asynchronous active-low reset, forces both FSMs to idle
//   din          serial data, one bit per clock
//   mealy_flag   high while state is "101" and din is 0 (combinational)
//   moore_flag   high for the one cycle spent in the "1010" state
//   mealy_state  debug view of the Mealy state register (A0..A3 = 0..3)
//   moore_state  debug view of the Moore state register (M0..M4 = 0..4)
//
// A din value that is neither 0 nor 1 (X/Z in simulation) counts as a
// no-match: it never raises a flag and sends both machines back to idle.
module mealy_moore (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       mealy_flag,
  output logic       moore_flag,
  output logic [1:0] mealy_state,
  output logic [2:0] moore_state
);

  typedef enum logic [2:0] {
    M0 = 3'd0,  // idle
    M1 = 3'd1,  // "1"
    M2 = 3'd2,  // "10"
    M3 = 3'd3,  // "101"
    M4 = 3'd4   // "1010", detect
  } moore_t;

  typedef enum logic [1:0] {
    A0 = 2'd0,  // idle
    A1 = 2'd1,  // "1"
    A2 = 2'd2,  // "10"
    A3 = 2'd3   // "101"
  } mealy_t;

  moore_t moore_q, moore_d;
  mealy_t mealy_q, mealy_d;
  logic   is_one, is_zero;

  // Decode din with a case so an unknown value matches neither arm.
  always_comb begin
    is_one  = 1'b0;
    is_zero = 1'b0;
    case (din)
      1'b1:    is_one  = 1'b1;
      1'b0:    is_zero = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      moore_q <= M0;
      mealy_q <= A0;
    end else begin
      moore_q <= moore_d;
      mealy_q <= mealy_d;
    end
  end

  // Moore next state. Anything not listed (including the three unused
  // encodings) falls back to M0.
  always_comb begin
    moore_d = M0;
    case (moore_q)
      M0: if (is_one) moore_d = M1;
      M1: begin
        if (is_one)       moore_d = M1;
        else if (is_zero) moore_d = M2;
      end
      M2: if (is_one) moore_d = M3;
      M3: begin
        if (is_one)       moore_d = M1;
        else if (is_zero) moore_d = M4;
      end
      // From the detect state a 1 reuses the trailing "10" as a prefix.
      M4: if (is_one) moore_d = M3;
      default: moore_d = M0;
    endcase
  end

  // Mealy next state; a 0 in A3 completes a match and keeps "10" as prefix.
  always_comb begin
    mealy_d = A0;
    case (mealy_q)
      A0: if (is_one) mealy_d = A1;
      A1: begin
        if (is_one)       mealy_d = A1;
        else if (is_zero) mealy_d = A2;
      end
      A2: if (is_one) mealy_d = A3;
      A3: begin
        if (is_one)       mealy_d = A1;
        else if (is_zero) mealy_d = A2;
      end
      default: mealy_d = A0;
    endcase
  end

  assign moore_flag  = (moore_q == M4);
  assign mealy_flag  = (mealy_q == A3) && is_zero;
  assign moore_state = moore_q;
  assign mealy_state = mealy_q;

endmodule

// File: tb/tb_mealy_moore.sv
// Testbench for mealy_moore: a table of {rst, din, expected mealy, expected
// moore} records applied one per clock, followed by hand-written sequences
// for asynchronous reset and the overlapped state path.
module tb_mealy_moore;

  logic       clk;
  logic       rst;
  logic       din;
  logic       mealy_flag;
  logic       moore_flag;
  logic [1:0] mealy_state;
  logic [2:0] moore_state;

  int n_checks;
  int n_pass;

  mealy_moore dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .mealy_flag  (mealy_flag),
    .moore_flag  (moore_flag),
    .mealy_state (mealy_state),
    .moore_state (moore_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct packed {
    logic rst;
    logic din;
    logic em;   // expected mealy_flag before the sampling edge
    logic eo;   // expected moore_flag before the sampling edge
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic d, input logic m, input logic o);
    vec_t v;
    v.rst = r;
    v.din = d;
    v.em  = m;
    v.eo  = o;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Drive one bit at the falling edge without checking.
  task automatic drive(input logic d);
    @(negedge clk);
    rst = 1'b1;
    din = d;
  endtask

  // ---------------- stimulus and checking ----------------
  logic [31:0] stream;
  logic [31:0] match_mask;
  logic [2:0]  exp_moore_path [6];
  logic [1:0]  exp_mealy_path [6];
  logic [5:0]  path_bits;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    din      = 1'b0;
    #2 rst   = 1'b0;

    // Reset held with din toggling.
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 0);

    // Basic match 0,1,0,1,0.
    add(1, 0, 0, 0); add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 1, 0, 0);
    add(1, 0, 1, 0);
    add(1, 1, 0, 1);          // moore pulse one cycle later, now in A3/M3
    add(0, 0, 0, 0);          // reset in A3 with din=0: mealy must stay low

    // Long stream, LSB first. Matches end on bits 3,5,7,9,24,26,28.
    stream     = 32'h6AA36155;
    match_mask = 32'h150002A8;
    for (int i = 0; i < 32; i++)
      add(1, stream[i], match_mask[i], (i == 0) ? 1'b0 : match_mask[i-1]);
    add(1, 0, 0, 0);
    add(0, 1, 0, 0);

    // Near misses, then a single clean match.
    add(1, 1, 0, 0); add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 0, 0, 0);
    add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 0, 0, 0);
    add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 0, 0, 0); add(1, 1, 0, 0);
    add(1, 0, 0, 0);
    add(0, 1, 0, 0);
    add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 1, 0, 0); add(1, 0, 1, 0);
    add(1, 0, 0, 1);

    // Overlap chain 1,0,1,0,1,0,1,0.
    add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 1, 0, 0); add(1, 0, 1, 0);
    add(1, 1, 0, 1); add(1, 0, 1, 0); add(1, 1, 0, 1); add(1, 0, 1, 0);
    add(1, 1, 0, 1);

    // Reset mid-match discards the partial 1,0,1.
    add(0, 0, 0, 0);
    add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 1, 0, 0);
    add(0, 0, 0, 0);
    add(1, 0, 0, 0); add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 1, 0, 0);
    add(1, 0, 1, 0);
    add(1, 0, 0, 1);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst;
      din = vq[i].din;
      #1;
      check($sformatf("vec%0d mealy_flag", i), {3'b0, mealy_flag}, {3'b0, vq[i].em});
      check($sformatf("vec%0d moore_flag", i), {3'b0, moore_flag}, {3'b0, vq[i].eo});
    end

    // Asynchronous reset while the Mealy flag is up (state A3, din=0).
    @(negedge clk); rst = 1'b0;
    drive(1); drive(0); drive(1);
    @(negedge clk); din = 1'b0;
    #1 check("async pre mealy", {3'b0, mealy_flag}, 4'd1);
    #2 rst = 1'b0;             // clock still low, no edge
    #1;
    check("async mealy drop", {3'b0, mealy_flag}, 4'd0);
    check("async mealy idle", {2'b0, mealy_state}, 4'd0);
    check("async moore idle", {1'b0, moore_state}, 4'd0);

    // Asynchronous reset while in M4, just after the sampling edge.
    drive(1); drive(0); drive(1); drive(0);
    @(posedge clk);
    #1 check("async pre moore", {3'b0, moore_flag}, 4'd1);
    #1 rst = 1'b0;
    #1;
    check("async moore drop", {3'b0, moore_flag}, 4'd0);
    check("async moore state", {1'b0, moore_state}, 4'd0);
    check("async mealy flag", {3'b0, mealy_flag}, 4'd0);

    // Held in reset over two clocks with din toggling.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); din = ~din;
      #1;
      check($sformatf("hold%0d mealy", k), {3'b0, mealy_flag}, 4'd0);
      check($sformatf("hold%0d moore", k), {3'b0, moore_flag}, 4'd0);
    end

    // State path through the overlap: 1,0,1,0,1,0.
    path_bits      = 6'b101010;   // index 5 sent first
    exp_moore_path = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4};
    exp_mealy_path = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
    for (int k = 0; k < 6; k++) begin
      drive(path_bits[5-k]);
      @(posedge clk);
      #1;
      check($sformatf("path%0d moore_state", k), {1'b0, moore_state}, {1'b0, exp_moore_path[k]});
      check($sformatf("path%0d mealy_state", k), {2'b0, mealy_state}, {2'b0, exp_mealy_path[k]});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
